// File: rtl/mod_mul_iter.sv
// Iterative modular multiplier: (A*B) mod Q by MSB-first interleaved double-and-add,
// one bit of B per enabled clock, with a small IDLE/RUN/DONE controller.
module mod_mul_iter #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iStart,
  input  logic [BITWIDTH-1:0] iA,
  input  logic [BITWIDTH-1:0] iB,
  input  logic [BITWIDTH-1:0] iQ,
  output logic [BITWIDTH-1:0] oData,
  output logic                oBusy,
  output logic                oDone
);

  localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] CNT_TOP = CW'(BITWIDTH - 1);

  logic [1:0]          state;
  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] a_cap;
  logic [BITWIDTH-1:0] b_cap;
  logic [BITWIDTH-1:0] q_cap;
  logic [CW-1:0]       cnt;

  logic [BITWIDTH:0]   q_ext;
  logic [BITWIDTH:0]   dbl;
  logic [BITWIDTH:0]   dbl_red;
  logic [BITWIDTH:0]   sum;
  logic [BITWIDTH-1:0] acc_nxt;

  // One extra bit keeps 2*acc and acc+A exact for any modulus up to 2^BITWIDTH-1.
  assign q_ext   = {1'b0, q_cap};
  assign dbl     = {acc, 1'b0};
  assign dbl_red = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
  assign sum     = dbl_red + (b_cap[cnt] ? {1'b0, a_cap} : '0);
  assign acc_nxt = BITWIDTH'((sum >= q_ext) ? (sum - q_ext) : sum);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      a_cap <= '0;
      b_cap <= '0;
      q_cap <= '0;
      oData <= '0;
    end else if (iClr) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      oData <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            a_cap <= iA;
            b_cap <= iB;
            q_cap <= iQ;
            acc   <= '0;
            cnt   <= CNT_TOP;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (iEn) begin
            acc <= acc_nxt;
            // The last step publishes the result; oData is untouched otherwise.
            if (cnt == '0) begin
              oData <= acc_nxt;
              state <= DONE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oBusy = (state == RUN);
  assign oDone = (state == DONE);

endmodule
